// File: rtl/mult4_arb_pkg.sv
// Shared types and widths for the mult4_arbitro shared-multiplier arbiter.
package mult4_arb_pkg;

   localparam int N_REQ = 2;
   localparam int OP_W  = 4;
   localparam int RES_W = 8;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   function automatic logic [N_REQ-1:0] id2onehot(input logic id);
      return N_REQ'(1) << id;
   endfunction

endpackage

// File: rtl/mult4_comb.sv
// Combinational 4x4 -> 8 bit unsigned multiplier, the resource shared by mult4_arbitro.
module mult4_comb
   import mult4_arb_pkg::*;
(
   input  logic [OP_W-1:0]  i_a,
   input  logic [OP_W-1:0]  i_b,
   output logic [RES_W-1:0] o_p
);

   assign o_p = RES_W'(i_a) * RES_W'(i_b);

endmodule

// File: rtl/mult4_arbitro.sv
// Two-requester arbiter in front of one shared 4x4 multiplier (IDLE/CALC/RESP).
// Define MULT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties), else round-robin.
module mult4_arbitro
   import mult4_arb_pkg::*;
#(
   parameter int LATENCY = 1
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req_valid,
   output logic [N_REQ-1:0] req_ready,
   input  logic [OP_W-1:0]  x0,
   input  logic [OP_W-1:0]  y0,
   input  logic [OP_W-1:0]  x1,
   input  logic [OP_W-1:0]  y1,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [RES_W-1:0] res_data,
   output logic             res_id,
   output logic             busy
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [OP_W-1:0]    r_xa;
   logic [OP_W-1:0]    r_ya;
   logic               r_id;
   logic [RES_W-1:0]   r_res;
   logic               w_win;
   logic               w_any;
   logic               w_accept;
   logic               w_calc_done;
   logic [RES_W-1:0]   w_prod;

   assign w_any       = |req_valid;
   assign w_accept    = |(req_ready & req_valid);
   assign w_calc_done = (r_state == CALC) && (r_cnt == '0);

`ifdef MULT_ARB_FIXED_PRIO_EN
   assign w_win = ~req_valid[0];
`else
   logic r_last;

   // On a tie the requester that was not served last wins.
   assign w_win = (&req_valid) ? ~r_last : ~req_valid[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 1'b1;
      end else if ((r_state == RESP) && res_ready) begin
         r_last <= r_id;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept)    w_state_nxt = CALC;
         CALC:    if (w_calc_done) w_state_nxt = RESP;
         RESP:    if (res_ready)   w_state_nxt = IDLE;
         default:                  w_state_nxt = IDLE;
      endcase
   end

   // Grant is combinational in IDLE; RESP->IDLE costs one cycle before the next grant.
   always_comb begin
      req_ready = '0;
      res_valid = 1'b0;
      busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (rst_n && w_any) begin
               req_ready = id2onehot(w_win);
            end
         end
         CALC: begin
            busy = 1'b1;
         end
         RESP: begin
            busy      = 1'b1;
            res_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if ((r_state == IDLE) && w_accept) begin
         r_cnt <= CNT_INIT;
      end else if ((r_state == CALC) && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Operand copy is pure data: no reset needed, only loaded on accept.
   always_ff @(posedge clk) begin
      if ((r_state == IDLE) && w_accept) begin
         r_xa <= w_win ? x1 : x0;
         r_ya <= w_win ? y1 : y0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_id  <= 1'b0;
         r_res <= '0;
      end else begin
         if ((r_state == IDLE) && w_accept) begin
            r_id <= w_win;
         end
         if (w_calc_done) begin
            r_res <= w_prod;
         end
      end
   end

   mult4_comb u_mult (
      .i_a (r_xa),
      .i_b (r_ya),
      .o_p (w_prod)
   );

   assign res_data = r_res;
   assign res_id   = r_id;

endmodule

// File: tb/tb_mult4_arbitro.sv
// Scoreboard bench for mult4_arbitro: LATENCY=1 instance for the main flow, LATENCY=4 for mid-CALC reset.
module tb_mult4_arbitro;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] req_valid, req_ready;
   logic [3:0] x0, y0, x1, y1;
   logic       res_valid, res_ready;
   logic [7:0] res_data;
   logic       res_id, busy;

   logic [1:0] v4, rdy4;
   logic [3:0] p0x, p0y, p1x, p1y;
   logic       rv4, rr4;
   logic [7:0] rd4;
   logic       rid4, busy4;

   always #5 clk = ~clk;

   mult4_arbitro #(.LATENCY(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_id(res_id), .busy(busy)
   );

   mult4_arbitro #(.LATENCY(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(rdy4),
      .x0(p0x), .y0(p0y), .x1(p1x), .y1(p1y),
      .res_valid(rv4), .res_ready(rr4), .res_data(rd4),
      .res_id(rid4), .busy(busy4)
   );

   typedef struct packed {
      logic       id;
      logic [7:0] data;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];
   logic g_hist[$];
   int   g_cyc;
   logic m_last, m_busy;
   logic prev_rv, prev_acc, prev_id;
   logic [7:0] prev_rd;
   logic [7:0] last_data;
   logic       last_id;
   exp_t       e;
   logic       w;
   logic [1:0] exp_rdy;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic pick(input logic [1:0] v, input logic last);
      if (v == 2'b10) return 1'b1;
      if (v == 2'b01) return 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~last;
`endif
   endfunction

   // Monitor: predicts grants, pushes expected products, pops on accepted results.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         chk("busy", busy, m_busy);
         if (m_busy) begin
            chk("ready_while_busy", req_ready, 0);
         end else begin
            exp_rdy = (req_valid == 2'b00) ? 2'b00 : (pick(req_valid, m_last) ? 2'b10 : 2'b01);
            chk("grant", req_ready, exp_rdy);
            if (req_valid != 2'b00) begin
               w = pick(req_valid, m_last);
               e.id   = w;
               e.data = w ? ({4'b0, x1} * {4'b0, y1}) : ({4'b0, x0} * {4'b0, y0});
               sb.push_back(e);
               g_hist.push_back(w);
               g_cyc  = cyc;
               m_busy = 1'b1;
            end
         end
         if (res_valid) begin
            if (!prev_rv) begin
               chk("latency", cyc - g_cyc, 2);
            end else if (!prev_acc) begin
               chk("hold_data", res_data, prev_rd);
               chk("hold_id", res_id, prev_id);
            end
            if (res_ready) begin
               if (sb.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_result: got %0d expected no result", res_data);
               end else begin
                  e = sb.pop_front();
                  chk("res_data", res_data, e.data);
                  chk("res_id", res_id, e.id);
                  m_last = e.id;
               end
               m_busy    = 1'b0;
               last_data = res_data;
               last_id   = res_id;
            end
         end
         prev_rv  = res_valid;
         prev_rd  = res_data;
         prev_id  = res_id;
         prev_acc = res_valid && res_ready;
      end
   end

   task automatic model_reset();
      m_last   = 1'b1;
      m_busy   = 1'b0;
      prev_rv  = 1'b0;
      prev_acc = 1'b0;
   endtask

   task automatic do_reset();
      chk("sb_empty_before_reset", sb.size(), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // sel: 0 rdy4[0], 1 rdy4[1], 2 rv4, 3 res_valid, 4 req_ready[1]
   task automatic wait_neg(input int sel, input string name, output int at);
      logic hit;
      at = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         case (sel)
            0:       hit = rdy4[0];
            1:       hit = rdy4[1];
            2:       hit = rv4;
            3:       hit = res_valid;
            default: hit = req_ready[1];
         endcase
         if (hit === 1'b1) begin
            at = cyc;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic do_req(input logic id, input logic [3:0] a, input logic [3:0] b);
      if (id) begin x1 = a; y1 = b; end
      else    begin x0 = a; y0 = b; end
      req_valid[id] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (req_ready[id] === 1'b1) begin
            @(posedge clk);
            #1;
            req_valid[id] = 1'b0;
            if (id) begin x1 = 4'($urandom); y1 = 4'($urandom); end
            else    begin x0 = 4'($urandom); y0 = 4'($urandom); end
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL grant_timeout: requester %0d got no ready expected ready", id);
      req_valid[id] = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            @(posedge clk);
            #1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, t1, c_rel;
      logic exp_order [4];
      rst_n = 1'b0; req_valid = 2'b11; res_ready = 1'b1;
      x0 = 0; y0 = 0; x1 = 0; y1 = 0;
      v4 = 2'b11; rr4 = 1'b1; p0x = 0; p0y = 0; p1x = 0; p1y = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst4_req_ready", rdy4, 0);
      req_valid = 2'b00;
      v4 = 2'b00;
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Test 1: single request from requester 0
      @(posedge clk); #1;
      do_req(1'b0, 4'd3, 4'd5);
      drain();
      chk("t1_data", last_data, 15);
      chk("t1_id", last_id, 0);

      // Test 2: both requesters held valid
      do_reset();
      g_hist.delete();
      x0 = 4'd3; y0 = 4'd5; x1 = 4'd2; y1 = 4'd7;
      req_valid = 2'b11;
      for (int i = 0; i < 100 && g_hist.size() < 4; i++) @(negedge clk);
      @(posedge clk); #1;
      req_valid = 2'b00;
      drain();
`ifdef MULT_ARB_FIXED_PRIO_EN
      exp_order = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      chk("t2_grant_count", (g_hist.size() >= 4) ? 1 : 0, 1);
      for (int i = 0; i < 4; i++) begin
         if (i < g_hist.size()) chk($sformatf("t2_order_%0d", i), g_hist[i], exp_order[i]);
      end

      // Test 3: maximum operands on requester 1
      do_req(1'b1, 4'd15, 4'd15);
      drain();
      chk("t3_data", last_data, 225);
      chk("t3_id", last_id, 1);

      // Test 4: consumer back-pressure in RESP with requester 1 waiting
      res_ready = 1'b0;
      do_req(1'b0, 4'd9, 4'd9);
      x1 = 4'd4; y1 = 4'd4;
      req_valid[1] = 1'b1;
      wait_neg(3, "t4_resp_timeout", t0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("t4_valid", res_valid, 1);
         chk("t4_data", res_data, 81);
         chk("t4_id", res_id, 0);
         chk("t4_no_ready", req_ready, 0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      c_rel = cyc;
      wait_neg(4, "t4_regrant_timeout", t1);
      chk("t4_regrant_gap", t1 - c_rel, 1);
      @(posedge clk); #1;
      req_valid[1] = 1'b0;
      drain();
      chk("t4_next_data", last_data, 16);
      chk("t4_next_id", last_id, 1);

      // Test 5: LATENCY=4 instance, reset in the middle of CALC
      p0x = 4'd6; p0y = 4'd7;
      v4 = 2'b01;
      wait_neg(0, "t5_grant0_timeout", t0);
      @(posedge clk); #1;
      v4 = 2'b00;
      wait_neg(2, "t5_resp_timeout", t1);
      chk("t5_latency", t1 - t0, 5);
      chk("t5_data", rd4, 42);
      chk("t5_id", rid4, 0);
      @(posedge clk); #1;
      p1x = 4'd7; p1y = 4'd3;
      v4 = 2'b10;
      wait_neg(1, "t5_grant1_timeout", t0);
      @(posedge clk); #1;
      v4 = 2'b00;
      @(posedge clk); #1;
      chk("t5_busy_calc", busy4, 1);
      chk("t5_id_latched", rid4, 1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_rst_ready", rdy4, 0);
      chk("t5_rst_valid", rv4, 0);
      chk("t5_rst_data", rd4, 0);
      chk("t5_rst_id", rid4, 0);
      chk("t5_rst_busy", busy4, 0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t5_no_resp", rv4, 0);
      end
      @(posedge clk); #1;
      p0x = 4'd1; p0y = 4'd2; p1x = 4'd3; p1y = 4'd3;
      v4 = 2'b11;
      @(negedge clk);
      chk("t5_tie_after_reset", rdy4, 2'b01);
      @(posedge clk); #1;
      v4 = 2'b00;
      wait_neg(2, "t5_resp2_timeout", t1);
      chk("t5_data2", rd4, 2);
      chk("t5_id2", rid4, 0);

      // Test 6: all 256 operand pairs on requester 0
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_req(1'b0, 4'(a), 4'(b));
         end
      end
      drain();
      chk("t6_last_data", last_data, 225);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
